// File: rtl/fc_seq_mac_if.sv
// Handshake and data bundle for the time-multiplexed FC neuron (fc_seq_mac).
// The master drives start/bias/beats and the output ready; the slave is the MAC block.
interface fc_seq_mac_if #(
  parameter int BIT_WIDTH = 32,
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 64,
  parameter int LANES     = 4
);
  logic                       start;
  logic [BIT_WIDTH-1:0]       bias;
  logic                       in_valid;
  logic                       in_ready;
  logic [IN_WIDTH*LANES-1:0]  in_data;
  logic [BIT_WIDTH*LANES-1:0] in_weights;
  logic                       out_valid;
  logic                       out_ready;
  logic [OUT_WIDTH-1:0]       out;
  logic                       busy;

  modport master (
    output start, bias, in_valid, in_data, in_weights, out_ready,
    input  in_ready, out_valid, out, busy
  );

  modport slave (
    input  start, bias, in_valid, in_data, in_weights, out_ready,
    output in_ready, out_valid, out, busy
  );
endinterface

// File: rtl/fc_seq_mac.sv
// Sequential FC neuron: out = bias + sum(in[k]*w[k]), LANES products per accepted beat.
// Build option: define FC_SEQ_RELU_EN to clamp negative results to zero at the output.
module fc_seq_mac #(
  parameter int BIT_WIDTH = 32,
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 64,
  parameter int N_IN      = 120,
  parameter int LANES     = 4
) (
  input logic         clk,
  input logic         rst,
  fc_seq_mac_if.slave bus
);
  localparam int BEATS      = (N_IN + LANES - 1) / LANES;
  localparam int LAST_LANES = N_IN - (BEATS - 1) * LANES;
  localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [CNT_W-1:0]            r_beat_cnt;
  logic signed [OUT_WIDTH-1:0] r_acc;
  logic signed [OUT_WIDTH-1:0] r_out;
  logic signed [OUT_WIDTH-1:0] w_sum;
  logic signed [OUT_WIDTH-1:0] w_acc_nxt;
  logic signed [OUT_WIDTH-1:0] w_out_nxt;
  logic signed [OUT_WIDTH-1:0] w_prod [LANES];
  logic                        w_accept;
  logic                        w_last;

  assign w_accept = (r_state == S_ACCUM) && bus.in_valid;
  assign w_last   = (r_beat_cnt == CNT_W'(BEATS - 1));

  // Lanes past the end of the neuron on the final beat carry padding, not data.
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic signed [OUT_WIDTH-1:0] w_a;
    logic signed [OUT_WIDTH-1:0] w_b;
    assign w_a       = OUT_WIDTH'($signed(bus.in_data[IN_WIDTH*j +: IN_WIDTH]));
    assign w_b       = OUT_WIDTH'($signed(bus.in_weights[BIT_WIDTH*j +: BIT_WIDTH]));
    assign w_prod[j] = (w_last && (j >= LAST_LANES)) ? '0 : w_a * w_b;
  end

  always_comb begin
    w_sum = '0;
    for (int j = 0; j < LANES; j++) w_sum = w_sum + w_prod[j];
  end

  assign w_acc_nxt = r_acc + w_sum;

`ifdef FC_SEQ_RELU_EN
  assign w_out_nxt = w_acc_nxt[OUT_WIDTH-1] ? '0 : w_acc_nxt;
`else
  assign w_out_nxt = w_acc_nxt;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) w_state_nxt = S_ACCUM;
      end
      S_ACCUM: begin
        bus.in_ready = 1'b1;
        if (w_accept && w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // r_out is loaded on the final beat so it already equals acc for the whole DONE state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc      <= '0;
      r_beat_cnt <= '0;
      r_out      <= '0;
    end else if ((r_state == S_IDLE) && bus.start) begin
      r_acc      <= OUT_WIDTH'($signed(bus.bias));
      r_beat_cnt <= '0;
    end else if (w_accept) begin
      r_acc <= w_acc_nxt;
      if (w_last) r_out <= w_out_nxt;
      else        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
    end
  end

  assign bus.out = r_out;
endmodule

// File: tb/tb_fc_seq_mac.sv
// Directed bench for fc_seq_mac: three configurations (120x4, 10x4, 1x1) on a shared clock.
// Expected ReLU-dependent results follow FC_SEQ_RELU_EN.
module tb_fc_seq_mac;
  logic clk = 1'b0;
  logic rst0, rst1, rst2;
  int   n_err = 0;
  int   n_chk = 0;

  always #5 clk = ~clk;

  fc_seq_mac_if #(.LANES(4)) if0 ();
  fc_seq_mac_if #(.LANES(4)) if1 ();
  fc_seq_mac_if #(.LANES(1)) if2 ();

  fc_seq_mac #(.N_IN(120), .LANES(4)) u0 (.clk(clk), .rst(rst0), .bus(if0.slave));
  fc_seq_mac #(.N_IN(10),  .LANES(4)) u1 (.clk(clk), .rst(rst1), .bus(if1.slave));
  fc_seq_mac #(.N_IN(1),   .LANES(1)) u2 (.clk(clk), .rst(rst2), .bus(if2.slave));

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic signed [63:0] relu(input logic signed [63:0] v);
`ifdef FC_SEQ_RELU_EN
    return (v < 0) ? 64'sd0 : v;
`else
    return v;
`endif
  endfunction

  logic signed [63:0] bin [10];
  logic signed [31:0] bw [10];
  logic signed [63:0] gold;
  logic signed [63:0] held;
  int cyc, beat, acc_beats;

  initial begin
    {if0.start, if0.in_valid, if0.out_ready, if0.bias, if0.in_data, if0.in_weights} = '0;
    {if1.start, if1.in_valid, if1.out_ready, if1.bias, if1.in_data, if1.in_weights} = '0;
    {if2.start, if2.in_valid, if2.out_ready, if2.bias, if2.in_data, if2.in_weights} = '0;
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    if0.start = 1'b1;
    tick(); tick();
    chk("rst_busy",      if0.busy, 0);
    chk("rst_out_valid", if0.out_valid, 0);
    chk("rst_in_ready",  if0.in_ready, 0);
    chk("rst_out",       if0.out, 0);
    if0.start = 1'b0;
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    tick();

    // 120 inputs of 1 weighted by 2 plus bias 5, in_valid held high
    if0.bias = 32'sd5; if0.in_valid = 1'b1;
    if0.in_data = {4{64'sd1}}; if0.in_weights = {4{32'sd2}};
    if0.start = 1'b1;
    cyc = 0;
    do begin tick(); if0.start = 1'b0; cyc++; end while (!if0.out_valid && cyc < 100);
    chk("t1_latency", cyc, 31);
    chk("t1_out", if0.out, relu(64'sd245));
    chk("t1_in_ready_done", if0.in_ready, 0);
    chk("t1_busy_done", if0.busy, 1);
    if0.out_ready = 1'b1;
    tick();
    if0.out_ready = 1'b0;
    chk("t1_valid_drop", if0.out_valid, 0);
    chk("t1_idle", if0.busy, 0);
    chk("t1_out_hold", if0.out, 64'sd245);

    // Negative sum: -100 + 120*(1*-1) = -220
    if0.bias = -32'sd100; if0.in_weights = {4{-32'sd1}};
    if0.start = 1'b1;
    cyc = 0;
    do begin tick(); if0.start = 1'b0; cyc++; end while (!if0.out_valid && cyc < 100);
    chk("t4_latency", cyc, 31);
    chk("t4_out", if0.out, relu(-64'sd220));
    if0.out_ready = 1'b1; tick(); if0.out_ready = 1'b0;

    // Reset after beat 7 accepted, then a fresh all-zero neuron
    if0.bias = 32'sd7; if0.in_data = {4{64'sd3}}; if0.in_weights = {4{32'sd1}};
    if0.start = 1'b1; tick(); if0.start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    rst0 = 1'b1; tick(); rst0 = 1'b0;
    chk("t5_rst_busy", if0.busy, 0);
    chk("t5_rst_valid", if0.out_valid, 0);
    chk("t5_rst_out", if0.out, 0);
    if0.bias = 32'sd0; if0.in_data = '0; if0.in_weights = {4{32'sd9}};
    if0.start = 1'b1;
    cyc = 0;
    do begin tick(); if0.start = 1'b0; cyc++; end while (!if0.out_valid && cyc < 100);
    chk("t5_no_early_valid", cyc, 31);
    chk("t5_out", if0.out, 0);
    if0.out_ready = 1'b1; tick(); if0.out_ready = 1'b0;

    // N_IN=10, LANES=4: in=k+1, w=1, garbage in masked lanes 2,3 of beat 2
    if1.bias = 32'sd0; if1.in_weights = {4{32'sd1}};
    if1.start = 1'b1; tick(); if1.start = 1'b0;
    acc_beats = 0;
    for (int b = 0; b < 3; b++) begin
      for (int l = 0; l < 4; l++) if1.in_data[64*l +: 64] = 64'(b*4 + l + 1);
      if (b == 2) begin
        if1.in_data[64*2 +: 64] = 64'sd1000;
        if1.in_data[64*3 +: 64] = -64'sd7;
      end
      if1.in_valid = 1'b1;
      if (if1.in_ready) acc_beats++;
      tick();
    end
    if1.in_valid = 1'b0;
    chk("t2_beats", acc_beats, 3);
    chk("t2_valid", if1.out_valid, 1);
    chk("t2_out", if1.out, relu(64'sd55));
    if1.out_ready = 1'b1; tick(); if1.out_ready = 1'b0;

    // Bubbles on in_valid, mixed-sign operands, out_ready held low for 5 cycles
    for (int k = 0; k < 10; k++) begin
      bin[k] = 64'(k - 4);
      bw[k]  = (k % 2 == 1) ? -32'sd2 : 32'sd5;
    end
    gold = -64'sd3;
    for (int k = 0; k < 10; k++) gold = gold + bin[k] * 64'(bw[k]);
    if1.bias = -32'sd3;
    if1.start = 1'b1; tick(); if1.start = 1'b0;
    beat = 0; cyc = 0;
    while (beat < 3 && cyc < 200) begin
      if1.in_data = '0; if1.in_weights = '0;
      for (int l = 0; l < 4; l++) begin
        if (beat*4 + l < 10) begin
          if1.in_data[64*l +: 64]    = bin[beat*4 + l];
          if1.in_weights[32*l +: 32] = bw[beat*4 + l];
        end
      end
      if1.in_valid = 1'($urandom_range(0, 1));
      if (if1.in_valid && if1.in_ready) beat++;
      tick();
      cyc++;
    end
    if1.in_valid = 1'b0;
    chk("t3_beats_in_budget", beat, 3);
    held = relu(gold);
    for (int i = 0; i < 5; i++) begin
      chk("t3_valid_held", if1.out_valid, 1);
      chk("t3_out_stable", if1.out, held);
      chk("t3_in_ready_done", if1.in_ready, 0);
      tick();
    end
    // start together with the handshake must not be taken until the next cycle
    if1.out_ready = 1'b1; if1.start = 1'b1;
    tick();
    if1.out_ready = 1'b0;
    chk("t3_valid_drop", if1.out_valid, 0);
    chk("t3_start_not_taken", if1.busy, 0);
    tick();
    if1.start = 1'b0;
    chk("t3_start_next_cycle", if1.busy, 1);
    rst1 = 1'b1; tick(); rst1 = 1'b0;

    // N_IN=1, LANES=1: 2^62*4 wraps to 0; start pulses while busy are ignored
    if2.bias = 32'sd0; if2.in_data = 64'sh4000_0000_0000_0000; if2.in_weights = 32'sd4;
    if2.start = 1'b1; tick();
    for (int i = 0; i < 3; i++) begin
      if2.start = (i != 1);
      tick();
      chk("t6_busy_accum", if2.busy, 1);
      chk("t6_in_ready_accum", if2.in_ready, 1);
    end
    if2.start = 1'b0; if2.in_valid = 1'b1;
    tick();
    if2.in_valid = 1'b0;
    chk("t6_valid", if2.out_valid, 1);
    chk("t6_wrap_out", if2.out, 0);
    if2.out_ready = 1'b1; tick(); if2.out_ready = 1'b0;

    if2.bias = 32'sd30; if2.in_data = -64'sd3; if2.in_weights = 32'sd7;
    if2.start = 1'b1; tick(); if2.start = 1'b0;
    if2.in_valid = 1'b1; tick(); if2.in_valid = 1'b0;
    chk("t6_valid2", if2.out_valid, 1);
    chk("t6_out2", if2.out, relu(64'sd9));
    if2.out_ready = 1'b1; tick(); if2.out_ready = 1'b0;
    chk("t6_idle", if2.busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
